// File: rtl/reg_loader_if.sv
// Request, data-stream and register-file write-port signals of the load sequencer.
// The master modport is the environment side; the slave modport is the loader side.
interface reg_loader_if #(
  parameter int N_THREADS     = 16,
  parameter int N_THREADS_MSB = $clog2(N_THREADS) - 1
);
  logic                     req_valid;
  logic                     req_ready;
  logic [N_THREADS_MSB:0]   req_thread_num;
  logic [3:0]               req_reg_addr;
  logic [3:0]               req_len;
  logic [31:0]              din;
  logic                     din_valid;
  logic                     din_ready;
  logic                     cpu_wr_en;
  logic [31:0]              mem_din;
  logic                     mem_wr_en;
  logic [3:0]               wr_addr;
  logic [N_THREADS_MSB:0]   wr_thread_num;
  logic                     done;
  logic [N_THREADS_MSB:0]   done_thread_num;
  logic                     busy;

  modport master (
    output req_valid, req_thread_num, req_reg_addr, req_len, din, din_valid, cpu_wr_en,
    input  req_ready, din_ready, mem_din, mem_wr_en, wr_addr, wr_thread_num,
           done, done_thread_num, busy
  );

  modport slave (
    input  req_valid, req_thread_num, req_reg_addr, req_len, din, din_valid, cpu_wr_en,
    output req_ready, din_ready, mem_din, mem_wr_en, wr_addr, wr_thread_num,
           done, done_thread_num, busy
  );
endinterface

// File: rtl/reg_loader.sv
// Load sequencer: queues {thread, reg, len} requests and streams 32-bit words into
// consecutive registers of the target thread, yielding the write port to CPU write-back.
module reg_loader #(
  parameter int N_THREADS     = 16,
  parameter int N_THREADS_MSB = $clog2(N_THREADS) - 1,
  parameter int REQ_DEPTH     = 4
) (
  input  logic        CLK,
  input  logic        rst,
  reg_loader_if.slave bus
);
  localparam int          PW      = $clog2(REQ_DEPTH);
  localparam logic [PW:0] PTR_ONE = (PW + 1)'(1);

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_e;

  typedef struct packed {
    logic [N_THREADS_MSB:0] thread;
    logic [3:0]             addr;
    logic [3:0]             len;
  } req_t;

  state_e                 state_q;
  req_t                   fifo_q [REQ_DEPTH];
  req_t                   head;
  req_t                   req_in;
  logic [PW:0]            wptr_q, rptr_q;
  logic [N_THREADS_MSB:0] cur_thread_q;
  logic [3:0]             cur_addr_q;
  logic [3:0]             cnt_q;
  logic                   empty, full, push, pop, hs;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty  = (wptr_q == rptr_q);
  assign full   = (wptr_q[PW] != rptr_q[PW]) && (wptr_q[PW-1:0] == rptr_q[PW-1:0]);
  assign push   = bus.req_valid && bus.req_ready;
  assign pop    = (state_q == IDLE) && !empty;
  assign hs     = (state_q == LOAD) && bus.din_valid && !bus.cpu_wr_en;
  assign head   = fifo_q[rptr_q[PW-1:0]];
  assign req_in = '{thread: bus.req_thread_num, addr: bus.req_reg_addr, len: bus.req_len};

  assign bus.req_ready       = !full && !rst;
  assign bus.din_ready       = (state_q == LOAD) && !bus.cpu_wr_en;
  assign bus.mem_wr_en       = hs;
  assign bus.mem_din         = bus.din;
  assign bus.wr_addr         = cur_addr_q;
  assign bus.wr_thread_num   = cur_thread_q;
  assign bus.done            = (state_q == DONE);
  assign bus.done_thread_num = cur_thread_q;
  assign bus.busy            = (state_q != IDLE) || !empty;

  always_ff @(posedge CLK) begin
    if (push) begin
      fifo_q[wptr_q[PW-1:0]] <= req_in;
    end
  end

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + PTR_ONE;
      if (pop)  rptr_q <= rptr_q + PTR_ONE;
    end
  end

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cur_thread_q <= '0;
      cur_addr_q   <= '0;
      cnt_q        <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (pop) begin
            cur_thread_q <= head.thread;
            cur_addr_q   <= head.addr;
            cnt_q        <= head.len;
            state_q      <= LOAD;
          end
        end
        LOAD: begin
          if (hs) begin
            // Address wraps within the thread's 16 registers.
            cur_addr_q <= cur_addr_q + 4'd1;
            cnt_q      <= cnt_q - 4'd1;
            if (cnt_q == 4'd0) state_q <= DONE;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_reg_loader.sv
// Directed bench for reg_loader: register-file model fed from the write port,
// with write/done logs checked against hand-computed cycles, addresses and data.
module tb_reg_loader;
  logic clk;
  logic rst;
  int   cyc;
  int   n_checks;
  int   n_pass;

  reg_loader_if #(.N_THREADS(16)) bus ();

  reg_loader #(.N_THREADS(16), .REQ_DEPTH(4)) dut (
    .CLK (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc++;

  // Register-file model and write/done logs, sampled mid-cycle.
  logic [31:0] rf    [16][16];
  int          w_cyc [128];
  logic [3:0]  w_thr [128];
  logic [3:0]  w_adr [128];
  logic [31:0] w_dat [128];
  int          wn;
  int          d_cyc [32];
  logic [3:0]  d_thr [32];
  int          dn;
  int          conflicts;

  always @(negedge clk) begin
    if (bus.mem_wr_en && wn < 128) begin
      w_cyc[wn] = cyc;
      w_thr[wn] = bus.wr_thread_num;
      w_adr[wn] = bus.wr_addr;
      w_dat[wn] = bus.mem_din;
      rf[bus.wr_thread_num][bus.wr_addr] = bus.mem_din;
      wn++;
    end
    if (bus.done && dn < 32) begin
      d_cyc[dn] = cyc;
      d_thr[dn] = bus.done_thread_num;
      dn++;
    end
    if (bus.mem_wr_en && bus.cpu_wr_en) conflicts++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  logic [31:0] src [33];
  int          src_idx;
  int          src_len;

  task automatic load_src(input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++) src[i] = base + 32'(i);
    src_idx = 0;
    src_len = n;
  endtask

  // One clock cycle: drive stream/cpu inputs, note the handshake, advance past the edge.
  task automatic step(input logic v, input logic c);
    logic hs;
    bus.din_valid = v && (src_idx < src_len);
    bus.din       = bus.din_valid ? src[src_idx] : 32'h0;
    bus.cpu_wr_en = c;
    #2;
    hs = bus.din_valid && bus.din_ready;
    @(posedge clk);
    #1;
    if (hs) src_idx++;
  endtask

  task automatic set_req(input logic [3:0] thr, input logic [3:0] adr, input logic [3:0] len);
    bus.req_valid      = 1'b1;
    bus.req_thread_num = thr;
    bus.req_reg_addr   = adr;
    bus.req_len        = len;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  int             t0, wb, db, cnt13;
  logic [15:0]    gap_pat;
  logic [3:0]     exp_a [4];
  logic [3:0]     t4_thr [5];

  initial begin
    n_checks = 0; n_pass = 0; cyc = 0; wn = 0; dn = 0; conflicts = 0;
    for (int t = 0; t < 16; t++)
      for (int r = 0; r < 16; r++) rf[t][r] = 32'h0;
    src_idx = 0; src_len = 0;
    rst = 1'b1;
    bus.req_valid = 1'b0; bus.req_thread_num = '0; bus.req_reg_addr = '0; bus.req_len = '0;
    bus.din = '0; bus.din_valid = 1'b0; bus.cpu_wr_en = 1'b0;

    // Reset state
    #1;
    check("rst_req_ready",  32'(bus.req_ready), 0);
    check("rst_din_ready",  32'(bus.din_ready), 0);
    check("rst_mem_wr_en",  32'(bus.mem_wr_en), 0);
    check("rst_done",       32'(bus.done), 0);
    check("rst_busy",       32'(bus.busy), 0);
    check("rst_wr_addr",    32'(bus.wr_addr), 0);
    check("rst_wr_thread",  32'(bus.wr_thread_num), 0);
    check("rst_done_thr",   32'(bus.done_thread_num), 0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("rel_req_ready", 32'(bus.req_ready), 1);
    step(0, 0);

    // Single request: thread 5, reg 2, 4 words
    load_src(32'hA0, 4); wb = wn; db = dn;
    set_req(4'd5, 4'd2, 4'd3);
    t0 = cyc;
    step(1, 0);
    bus.req_valid = 1'b0;
    repeat (8) step(1, 0);
    check("t1_nwr", wn - wb, 4);
    for (int i = 0; i < 4; i++) begin
      check("t1_addr", 32'(w_adr[wb+i]), 32'(2 + i));
      check("t1_thr",  32'(w_thr[wb+i]), 5);
      check("t1_data", w_dat[wb+i], 32'hA0 + 32'(i));
      check("t1_cyc",  w_cyc[wb+i] - t0, 32'(2 + i));
      check("t1_rf",   rf[5][2+i], 32'hA0 + 32'(i));
    end
    check("t1_ndone",    dn - db, 1);
    check("t1_done_cyc", d_cyc[db] - t0, 6);
    check("t1_done_thr", 32'(d_thr[db]), 5);
    check("t1_busy",     32'(bus.busy), 0);

    // Address wrap: thread 9, reg 14, 4 words
    load_src(32'hB0, 4); wb = wn; db = dn;
    exp_a[0] = 4'd14; exp_a[1] = 4'd15; exp_a[2] = 4'd0; exp_a[3] = 4'd1;
    set_req(4'd9, 4'd14, 4'd3);
    step(1, 0);
    bus.req_valid = 1'b0;
    repeat (8) step(1, 0);
    check("t2_nwr", wn - wb, 4);
    for (int i = 0; i < 4; i++) begin
      check("t2_addr", 32'(w_adr[wb+i]), 32'(exp_a[i]));
      check("t2_thr",  32'(w_thr[wb+i]), 9);
    end
    check("t2_rf_wrap",  rf[9][0], 32'hB2);
    check("t2_rf_next",  rf[10][0], 32'h0);
    check("t2_rf_prev",  rf[8][15], 32'h0);
    check("t2_done_thr", 32'(d_thr[db]), 9);

    // Contention: cpu_wr_en on alternate cycles over a 16-word load
    load_src(32'hC00, 16); wb = wn; db = dn;
    set_req(4'd3, 4'd0, 4'd15);
    t0 = cyc;
    step(1, 0);
    bus.req_valid = 1'b0;
    for (int k = 0; k < 40; k++) step(1, (k % 2) == 1);
    bus.cpu_wr_en = 1'b0;
    check("t3_nwr", wn - wb, 16);
    for (int i = 0; i < 16; i++) begin
      check("t3_data", w_dat[wb+i], 32'hC00 + 32'(i));
      check("t3_addr", 32'(w_adr[wb+i]), 32'(i));
    end
    check("t3_first_cyc", w_cyc[wb] - t0, 3);
    check("t3_last_cyc",  w_cyc[wb+15] - t0, 33);
    check("t3_done_cyc",  d_cyc[db] - t0, 34);
    check("t3_conflicts", conflicts, 0);

    // FIFO full: five back-to-back requests, no data offered
    load_src(32'hD0, 5); wb = wn; db = dn;
    t4_thr[0] = 4'd1; t4_thr[1] = 4'd2; t4_thr[2] = 4'd3; t4_thr[3] = 4'd4; t4_thr[4] = 4'd6;
    for (int r = 0; r < 5; r++) begin
      set_req(t4_thr[r], 4'd7, 4'd0);
      #1;
      check("t4_ready", 32'(bus.req_ready), 1);
      step(0, 0);
    end
    set_req(4'd15, 4'd0, 4'd0);
    #1;
    check("t4_full", 32'(bus.req_ready), 0);
    check("t4_busy", 32'(bus.busy), 1);
    step(0, 0);
    bus.req_valid = 1'b0;
    repeat (25) step(1, 0);
    check("t4_ndone", dn - db, 5);
    check("t4_nwr",   wn - wb, 5);
    for (int r = 0; r < 5; r++) begin
      check("t4_order", 32'(d_thr[db+r]), 32'(t4_thr[r]));
      check("t4_rf",    rf[t4_thr[r]][7], 32'hD0 + 32'(r));
    end

    // din_valid gaps: thread 12, reg 4, 6 words
    load_src(32'hE0, 6); wb = wn; db = dn;
    gap_pat = 16'hFF4D;
    set_req(4'd12, 4'd4, 4'd5);
    t0 = cyc;
    step(1, 0);
    bus.req_valid = 1'b0;
    for (int k = 0; k < 16; k++) step(gap_pat[k], 0);
    check("t5_nwr", wn - wb, 6);
    for (int i = 0; i < 6; i++) begin
      check("t5_data", w_dat[wb+i], 32'hE0 + 32'(i));
      check("t5_addr", 32'(w_adr[wb+i]), 32'(4 + i));
    end
    check("t5_w2_cyc",   w_cyc[wb+2] - t0, 7);
    check("t5_last_cyc", w_cyc[wb+5] - t0, 11);
    check("t5_done_cyc", d_cyc[db] - t0, 12);

    // Reset mid-load after 3 of 8 words, with a second request queued
    load_src(32'hF0, 8); wb = wn; db = dn;
    set_req(4'd7, 4'd3, 4'd7);
    t0 = cyc;
    step(1, 0);
    bus.req_valid = 1'b0;
    step(1, 0);
    set_req(4'd13, 4'd0, 4'd0);
    step(1, 0);
    bus.req_valid = 1'b0;
    step(1, 0);
    step(1, 0);
    rst = 1'b1;
    #1;
    check("t6_mem_wr_en", 32'(bus.mem_wr_en), 0);
    check("t6_din_ready", 32'(bus.din_ready), 0);
    check("t6_busy",      32'(bus.busy), 0);
    check("t6_req_ready", 32'(bus.req_ready), 0);
    check("t6_wr_addr",   32'(bus.wr_addr), 0);
    check("t6_wr_thr",    32'(bus.wr_thread_num), 0);
    step(0, 0);
    step(0, 0);
    rst = 1'b0;
    #1;
    check("t6_rel_ready", 32'(bus.req_ready), 1);
    check("t6_rel_busy",  32'(bus.busy), 0);
    check("t6_nwr_abort", wn - wb, 3);
    check("t6_no_done",   dn - db, 0);
    load_src(32'h1230, 2); wb = wn; db = dn;
    set_req(4'd7, 4'd10, 4'd1);
    step(1, 0);
    bus.req_valid = 1'b0;
    repeat (8) step(1, 0);
    check("t6_nwr_new",   wn - wb, 2);
    check("t6_addr0",     32'(w_adr[wb]), 10);
    check("t6_addr1",     32'(w_adr[wb+1]), 11);
    check("t6_thr",       32'(w_thr[wb]), 7);
    check("t6_ndone",     dn - db, 1);
    check("t6_done_thr",  32'(d_thr[db]), 7);
    cnt13 = 0;
    for (int i = 0; i < wn; i++) if (w_thr[i] == 4'd13) cnt13++;
    check("t6_no_thr13",  cnt13, 0);
    check("t6_rf_kept",   rf[7][5], 32'hF2);
    check("t6_rf_unwr",   rf[7][6], 32'h0);
    check("t6_rf_new",    rf[7][11], 32'h1231);

    check("conflicts", conflicts, 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/reg_loader.md
# reg_loader

Load sequencer that sits directly upstream of the per-thread register file on its memory write port. It queues load requests (thread, start register, word count), accepts 32-bit words from a valid/ready data stream, and writes them into consecutive registers of the target thread through the register file's `mem_din` / `mem_wr_en` / `wr_addr` / `wr_thread_num` inputs. It yields the single write port to CPU write-back (`wr_en`) on a cycle-by-cycle basis and pulses `done` once each request has fully landed.

## Interface
- `N_THREADS`, 16: threads in the register file; 16 registers per thread.
- `N_THREADS_MSB`, `` `MSB(N_THREADS-1) ``: MSB of thread number.
- `REQ_DEPTH`, 4: request FIFO depth (power of 2, ≥2).

Ports:
- `CLK`  in  1  clock.
- `rst`  in  1  asynchronous, active-high reset.
- `req_valid`  in  1  load request offered.
- `req_ready`  out  1  request FIFO not full.
- `req_thread_num`  in  N_THREADS_MSB+1  target thread.
- `req_reg_addr`  in  4 (`` `REG_ADDR_MSB ``+1)  first register.
- `req_len`  in  4  word count minus 1; 0 means 1 word, 15 means 16 words.
- `din`  in  32  data word.
- `din_valid`  in  1  data word offered.
- `din_ready`  out  1  loader takes `din` this cycle.
- `cpu_wr_en`  in  1  CPU write-back owns the register-file write port this cycle (same signal as register-file `wr_en`).
- `mem_din`  out  32  to register file.
- `mem_wr_en`  out  1  to register file.
- `wr_addr`  out  4  to register file.
- `wr_thread_num`  out  N_THREADS_MSB+1  to register file.
- `done`  out  1  one-cycle pulse: request completed.
- `done_thread_num`  out  N_THREADS_MSB+1  thread of completed request, valid with `done`.
- `busy`  out  1  FSM not IDLE or FIFO non-empty.

## Operation
- Request FIFO with `REQ_DEPTH` entries, each holding {thread, reg_addr, len}.
  - Push when `req_valid && req_ready`.
  - `req_ready` = !full; there is no bypass. When full, a push is refused even in a cycle where the FSM pops.
- FSM states and transitions:
  - IDLE: if the FIFO is non-empty, pop the head into `cur_thread`, `cur_addr`, `cnt` <= len; go to LOAD.
  - LOAD: `din_ready` = !`cpu_wr_en` (combinational). On a handshake (`din_valid && din_ready`), write `din` into register `cur_addr` of `cur_thread`. Then `cur_addr` <= `cur_addr`+1 (4-bit wrap, 15→0, staying within the same thread) and `cnt` <= `cnt`-1. A handshake when `cnt`==0 moves to DONE.
  - DONE: `done`=1 and `done_thread_num`=`cur_thread` for exactly one cycle; go to IDLE.
- Write-port outputs are combinational from the state registers and the handshake:
  - `mem_wr_en` = LOAD && `din_valid` && !`cpu_wr_en`.
  - `mem_din` = `din`.
  - `wr_addr` = `cur_addr`.
  - `wr_thread_num` = `cur_thread`.
- `mem_wr_en` and `cpu_wr_en` are never high in the same cycle.
- `din_ready` is 0 in IDLE and DONE. Words offered outside LOAD are not consumed.
- `mem_din`, `wr_addr` and `wr_thread_num` may carry arbitrary values when `mem_wr_en`=0.

## Timing
- Reset (asynchronous, takes effect immediately):
  - FSM to IDLE, FIFO emptied, `cur_addr`/`cnt`/`cur_thread` = 0.
  - `req_ready`=0 while `rst` is high; 1 the first cycle after release.
  - `din_ready`, `mem_wr_en`, `done`, `busy` = 0.
  - `done_thread_num`, `wr_addr`, `wr_thread_num` = 0.
- Latency:
  - Request accepted at edge T: FIFO non-empty in cycle T+1, FSM in LOAD at T+2. First write earliest in cycle T+2.
  - Throughput: 1 word/cycle when `din_valid`=1 and `cpu_wr_en`=0.
  - The last word written in cycle W gives `done` in cycle W+1 and IDLE at W+2.
  - Back-to-back requests: 2 idle cycles (DONE, IDLE) between the last write of one request and the first write of the next.
- Stalls: each cycle with `cpu_wr_en`=1 in LOAD delays the transfer by one cycle. Address and count are unchanged and no word is lost.
- Reset mid-LOAD: the load aborts, registers already written stay written, no `done` pulse, and queued requests are discarded.
- A FIFO push during the cycle IDLE pops the last entry is legal; the new entry is served after DONE.

## Test plan
- Single request thread 5, reg 2, len 3, `din` = A0..A3 streamed continuously → writes to addr 2,3,4,5 of thread 5 in cycles T+2..T+5; `done`=1 with `done_thread_num`=5 at T+6; reading back via the register file gives A0..A3.
- Wrap: reg 14, len 3 → `wr_addr` sequence 14,15,0,1, `wr_thread_num` constant; no write to an adjacent thread.
- Contention: `cpu_wr_en` high on alternating cycles during a 16-word load (len 15) → `mem_wr_en` and `cpu_wr_en` never both 1; all 16 words land in order; `done` delayed by exactly the number of stall cycles.
- FIFO full: push 5 requests back-to-back with `din_valid`=0 → `req_ready` drops after the FIFO holds 4 entries (one request was already popped into LOAD); requests complete in submission order with 4 `done` pulses later plus 1.
- `din_valid` gaps: random `din_valid` pattern → data order preserved, `cnt` decrements only on handshake.
- Reset asserted mid-load after 3 of 8 words → outputs 0 immediately, no `done`, the next request after release starts cleanly at its own `req_reg_addr`.
